// File: rtl/rv523_alu_pkg.sv
// Shared definitions for the RV523 bit-serial ALU: operation codes and sequencer states.
package rv523_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // ADD and SUB propagate a carry; the logic ops do not.
  function automatic logic op_is_arith(alu_op_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/serial_alu_slice.sv
// One-bit combinational ALU slice. Written as a NAND network so the later
// mapping onto NAND library cells is a direct translation.
module serial_alu_slice
  import rv523_alu_pkg::*;
(
  input  logic    a_i,
  input  logic    b_i,
  input  logic    c_i,
  input  alu_op_e op_i,
  output logic    s_o,
  output logic    c_o
);

  logic n_ab, x_ab, n_xc, sum;

  // a^b and a^b^c as four-NAND XORs that share their first gate
  assign n_ab = ~(a_i & b_i);
  assign x_ab = ~(~(a_i & n_ab) & ~(b_i & n_ab));
  assign n_xc = ~(x_ab & c_i);
  assign sum  = ~(~(x_ab & n_xc) & ~(c_i & n_xc));

  // majority(a,b,c) = ab | (a^b)c, reusing both shared NANDs
  assign c_o  = ~(n_ab & n_xc);

  // Result bit selected by operation
  always_comb begin
    s_o = sum;
    unique case (op_i)
      OP_ADD, OP_SUB: s_o = sum;
      OP_AND:         s_o = ~n_ab;
      OP_XOR:         s_o = x_ab;
      default:        s_o = sum;
    endcase
  end

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: latches two operands, streams them LSB-first through
// a single slice one bit per clock, and presents the result with a done pulse.
module serial_alu_seq
  import rv523_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  alu_op_e          op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  // Only WIDTH-1 bits are stored: the final slice bit goes straight into result.
  logic [WIDTH-2:0] sh_r_q, sh_r_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;

  logic             s_bit, c_bit;
  logic [WIDTH-1:0] r_next;
  logic             accept;
  alu_op_e          op_in;

  assign op_in  = alu_op_e'(op);
  assign accept = start && ((state_q == IDLE) || (state_q == DONE));
  assign r_next = {s_bit, sh_r_q};

  serial_alu_slice u_slice (
    .a_i  (sh_a_q[0]),
    .b_i  (sh_b_q[0]),
    .c_i  (carry_q),
    .op_i (op_q),
    .s_o  (s_bit),
    .c_o  (c_bit)
  );

  // Next-state and datapath: load on accept, shift one bit per RUN cycle
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    sh_a_d   = sh_a_q;
    sh_b_d   = sh_b_q;
    sh_r_d   = sh_r_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          state_d = RUN;
          op_d    = op_in;
          cnt_d   = '0;
          sh_a_d  = a;
          // Subtraction is a + ~b + 1: invert b here, seed the carry with 1
          sh_b_d  = (op_in == OP_SUB) ? ~b : b;
          carry_d = (op_in == OP_SUB);
        end
      end
      RUN: begin
        sh_a_d  = sh_a_q >> 1;
        sh_b_d  = sh_b_q >> 1;
        sh_r_d  = r_next[WIDTH-1:1];
        carry_d = op_is_arith(op_q) ? c_bit : 1'b0;
        if (cnt_q == CNT_LAST) begin
          state_d  = DONE;
          result_d = r_next;
          cout_d   = op_is_arith(op_q) ? c_bit : 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      cnt_q    <= '0;
      sh_a_q   <= '0;
      sh_b_q   <= '0;
      sh_r_q   <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      sh_a_q   <= sh_a_d;
      sh_b_q   <= sh_b_d;
      sh_r_q   <= sh_r_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Bench for serial_alu_seq: cycle-level behavioural model plus directed literal cases.
module tb_serial_alu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, carry_out;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ndone = 0;

  serial_alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;
  always @(negedge clk) if (done) ndone++;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: an accepted op finishes W cycles later with plain arithmetic.
  int           run_left = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_res = '0, p_res = '0;
  logic         m_c = 1'b0, p_c = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_left = 0; m_done = 1'b0; m_res = '0; m_c = 1'b0;
    end else if (run_left > 0) begin
      m_done   = 1'b0;
      run_left = run_left - 1;
      if (run_left == 0) begin
        m_done = 1'b1; m_res = p_res; m_c = p_c;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        case (op)
          2'b00: {p_c, p_res} = {1'b0, a} + {1'b0, b};
          2'b01: begin p_res = a - b; p_c = (a >= b); end
          2'b10: begin p_res = a & b; p_c = 1'b0; end
          default: begin p_res = a ^ b; p_c = 1'b0; end
        endcase
        run_left = W;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("busy", W'(busy), W'(run_left > 0));
    chk("done", W'(done), W'(m_done));
    chk("result", result, m_res);
    chk("carry_out", W'(carry_out), W'(m_c));
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0; a = $urandom; b = $urandom;
  endtask

  // Returns at the falling edge of the done cycle, or flags a timeout
  task automatic wait_done(input string name);
    for (int i = 0; i < W + 6; i++) begin
      @(negedge clk);
      if (done) return;
    end
    checks++; errors++;
    $display("FAIL %s: done timeout, got no pulse expected one within %0d cycles", name, W + 6);
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] er, input logic ec);
    issue(o, x, y);
    wait_done(name);
    chk(name, result, er);
    chk({name, "_c"}, W'(carry_out), W'(ec));
    tick();
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return W'(1);
      default: return W'($urandom);
    endcase
  endfunction

  int c1, c2, nd0;

  initial begin
    #1;
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_result", result, '0);
    chk("rst_carry", W'(carry_out), '0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Directed cases with hand-computed results
    issue(2'b00, 32'd5, 32'd7);
    c1 = cyc;
    wait_done("add5_7");
    chk("add5_7_latency", W'(cyc - c1), W'(W));
    chk("add5_7", result, 32'h0000000C);
    chk("add5_7_c", W'(carry_out), '0);
    tick();
    run_op("add_ovf", 2'b00, 32'hFFFFFFFF, 32'd1, 32'h00000000, 1'b1);
    run_op("sub3_5", 2'b01, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0);
    run_op("sub5_3", 2'b01, 32'd5, 32'd3, 32'h00000002, 1'b1);
    run_op("and", 2'b10, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0);
    run_op("xor", 2'b11, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0);

    // start held through RUN with changing operands: single result, single done
    nd0 = ndone;
    start = 1'b1; op = 2'b00; a = 32'd100; b = 32'd23;
    tick();
    for (int i = 0; i < W; i++) begin
      a = $urandom; b = $urandom; op = 2'($urandom);
      tick();
    end
    start = 1'b0;
    repeat (4) tick();
    chk("hold_result", result, 32'd123);
    chk("hold_ndone", W'(ndone - nd0), W'(1));

    // Back-to-back accept in the DONE cycle
    issue(2'b00, 32'd1, 32'd1);
    wait_done("b2b_first");
    c1 = cyc;
    chk("b2b_first", result, 32'd2);
    start = 1'b1; op = 2'b01; a = 32'd10; b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("b2b_second");
    c2 = cyc;
    chk("b2b_gap", W'(c2 - c1), W'(W + 1));
    chk("b2b_second", result, 32'd6);
    chk("b2b_second_c", W'(carry_out), W'(1));
    tick();

    // Reset in the middle of RUN
    nd0 = ndone;
    issue(2'b00, 32'h12345678, 32'h11111111);
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", W'(busy), '0);
    chk("abort_result", result, '0);
    chk("abort_done", W'(done), '0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (W + 5) tick();
    chk("abort_no_done", W'(ndone - nd0), '0);
    run_op("add2_2", 2'b00, 32'd2, 32'd2, 32'd4, 1'b0);

    // Random traffic, including starts during RUN and DONE
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 4) == 0);
      op = 2'($urandom);
      a = pick();
      b = pick();
      tick();
    end
    start = 1'b0;
    repeat (W + 4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
